clk_div_prog: RTL

Multi-channel programmable clock divider. Next generation of the fixed single-output divider used in the LED blink designs. Generates CHANNELS independent, registered, glitch-free divided clock-enable waveforms from one system clock. Each channel has a runtime-writable divisor, updated safely at period boundaries, plus a one-cycle terminal tick per period. Sits between the board oscillator domain logic and LED/PWM/timebase consumers; all outputs stay in the clk_i domain.

---
 rtl/clk_div_prog.sv | 105 ++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: CHANNELS independent programmable clock dividers with shadowed divisors.
// Optional macro CLK_DIV_SYNC_EN adds sync_i, which realigns every enabled channel.
module clk_div_prog #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 50,
  parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                div_wr_i,
  input  logic [SEL_W-1:0]    div_sel_i,
  input  logic [CNT_W-1:0]    div_data_i,
`ifdef CLK_DIV_SYNC_EN
  input  logic                sync_i,
`endif
  output logic                div_ack_o,
  output logic [CHANNELS-1:0] clk_o,
  output logic [CHANNELS-1:0] tick_o
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic wr_ok;
  logic sync_w;
  logic ack_q, ack_d;

`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range selects are dropped entirely: no shadow update and no ack.
  always_comb begin
    wr_ok = div_wr_i && (32'(div_sel_i) < 32'(CHANNELS));
    ack_d = wr_ok;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign div_ack_o = ack_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0] shd_eff;
    logic [CNT_W-1:0] half;
    logic             run_q, run_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             bound;

    // A period boundary is a wrap, a fresh start after enable, a parked (A=0)
    // channel or a sync strobe; only there may the active divisor change.
    always_comb begin
      wr_hit  = wr_ok && (div_sel_i == SEL_W'(g));
      shd_eff = wr_hit ? div_data_i : shd_q;
      shd_d   = shd_eff;
      bound   = !run_q || (act_q == '0) || (cnt_q == act_q - ONE) || sync_w;
      run_d   = en_i[g];
      cnt_d   = '0;
      act_d   = shd_eff;
      if (en_i[g] && !bound) begin
        cnt_d = cnt_q + ONE;
        act_d = act_q;
      end
      half   = (act_d >> 1) + {{(CNT_W-1){1'b0}}, act_d[0]};
      clk_d  = en_i[g] && (act_d != '0) && (cnt_d < half);
      tick_d = en_i[g] && (act_d != '0) && (cnt_d == act_d - ONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q  <= '0;
        act_q  <= DEF_DIV;
        shd_q  <= DEF_DIV;
        run_q  <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        run_q  <= run_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_o[g]  = clk_q;
    assign tick_o[g] = tick_q;
  end

endmodule
